shared_dmem_arbiter: RTL and testbench

//  Parametrised shared data memory for the N-core processor array: per-core request ports,

---
 rtl/shared_dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_shared_dmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_dmem_arbiter.sv
// Shared data memory for an N-core array: parallel reads, one round-robin write per cycle,
// power-up CLEAR that gates start_process, registered result taps and all-cores-done flag.
module shared_dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 256,
  parameter int NUM_TAPS  = 16,
  parameter int TAP_BASE  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES*DATA_W-1:0]   rdata,
  output logic [NUM_CORES-1:0]          ack,
  output logic [NUM_CORES-1:0]          addr_err,
  output logic                          start_process,
  output logic                          all_done,
  output logic [NUM_TAPS*DATA_W-1:0]    taps
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_clr_ptr;
  logic [PTR_W-1:0]            r_rr_ptr;
  logic [DATA_W-1:0]           r_mem [DEPTH];
  logic [NUM_CORES-1:0]        r_ack;
  logic [NUM_CORES-1:0]        r_err;
  logic [NUM_CORES*DATA_W-1:0] r_rdata;
  logic                        r_start;
  logic                        r_all_done;
  logic [NUM_TAPS*DATA_W-1:0]  r_taps;

  logic                        w_run;
  logic [NUM_CORES-1:0]        w_rd_req;
  logic [NUM_CORES-1:0]        w_wr_req;
  logic [NUM_CORES-1:0]        w_in_range;
  logic [IDX_W-1:0]            w_idx [NUM_CORES];
  logic                        w_wr_valid;
  logic [PTR_W-1:0]            w_grant;

  assign w_run    = (r_state == ST_RUN);
  assign w_rd_req = req & ~we & {NUM_CORES{w_run}};
  assign w_wr_req = req &  we & {NUM_CORES{w_run}};

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      w_in_range[k] = ({1'b0, addr[k*ADDR_W +: ADDR_W]} < (ADDR_W+1)'(DEPTH));
      w_idx[k]      = addr[k*ADDR_W +: IDX_W];
    end
  end

  // Descending scan so the writer closest at-or-after r_rr_ptr is the last (winning) assignment.
  // NOTE: always_comb uses blocking '=' with defaults first so no latch is inferred.
  always_comb begin
    w_wr_valid = 1'b0;
    w_grant    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_wr_req[PTR_W'((int'(r_rr_ptr) + i) % NUM_CORES)]) begin
        w_wr_valid = 1'b1;
        w_grant    = PTR_W'((int'(r_rr_ptr) + i) % NUM_CORES);
      end
    end
  end

  // NOTE: the array has no reset so it can map to RAM; the CLEAR sequence initialises it.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_valid && w_in_range[w_grant]) begin
      r_mem[w_idx[w_grant]] <= wdata[w_grant*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_rr_ptr   <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_rdata    <= '0;
      r_start    <= 1'b0;
      r_all_done <= 1'b0;
      r_taps     <= '0;
    end else begin
      r_start    <= w_run;
      r_all_done <= r_start & (&core_done);
      r_ack      <= '0;
      r_err      <= '0;

      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + IDX_W'(1);
        if (r_clr_ptr == IDX_W'(DEPTH - 1)) r_state <= ST_RUN;
      end else begin
        // Reads sample memory before this edge's write lands: read-before-write.
        for (int k = 0; k < NUM_CORES; k++) begin
          if (w_rd_req[k]) begin
            r_ack[k] <= 1'b1;
            r_err[k] <= ~w_in_range[k];
            r_rdata[k*DATA_W +: DATA_W] <= w_in_range[k] ? r_mem[w_idx[k]] : '0;
          end
        end
        if (w_wr_valid) begin
          r_ack[w_grant] <= 1'b1;
          r_err[w_grant] <= ~w_in_range[w_grant];
          r_rr_ptr       <= PTR_W'((int'(w_grant) + 1) % NUM_CORES);
        end
      end

      for (int i = 0; i < NUM_TAPS; i++) begin
        r_taps[i*DATA_W +: DATA_W] <= w_run ? r_mem[IDX_W'(TAP_BASE + i)] : '0;
      end
    end
  end

  assign rdata         = r_rdata;
  assign ack           = r_ack;
  assign addr_err      = r_err;
  assign start_process = r_start;
  assign all_done      = r_all_done;
  assign taps          = r_taps;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Bench for shared_dmem_arbiter: directed scenarios plus randomized traffic checked against
// an array/arithmetic model of the memory, round-robin pointer and read-before-write rule.
module tb_shared_dmem_arbiter;

  localparam int N     = 4;
  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int DEPTH = 256;
  localparam int NT    = 16;
  localparam int TBASE = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      we = '0;
  logic [N-1:0]      core_done = '0;
  logic [AW-1:0]     addr_a  [N];
  logic [DW-1:0]     wdata_a [N];
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N*DW-1:0]   rdata;
  logic [N-1:0]      ack;
  logic [N-1:0]      addr_err;
  logic              start_process;
  logic              all_done;
  logic [NT*DW-1:0]  taps;

  int                m_mem [DEPTH];
  int                m_rr;
  logic [N-1:0]      e_ack;
  logic [N-1:0]      e_err;
  logic [N*DW-1:0]   e_rdata;
  logic [NT*DW-1:0]  e_taps;
  int                n_checks = 0;
  int                n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      addr[k*AW +: AW]  = addr_a[k];
      wdata[k*DW +: DW] = wdata_a[k];
    end
  end

  shared_dmem_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .NUM_TAPS(NT), .TAP_BASE(TBASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .core_done(core_done), .rdata(rdata), .ack(ack), .addr_err(addr_err),
    .start_process(start_process), .all_done(all_done), .taps(taps)
  );

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_rr    = 0;
    e_rdata = '0;
  endfunction

  // One cycle of the memory's rules applied to the currently driven requests.
  function automatic void model_step();
    int g;
    int a;
    for (int i = 0; i < NT; i++) e_taps[i*DW +: DW] = DW'(m_mem[TBASE + i]);
    e_ack = '0;
    e_err = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k] && !we[k]) begin
        a        = int'(addr_a[k]);
        e_ack[k] = 1'b1;
        e_err[k] = (a >= DEPTH);
        e_rdata[k*DW +: DW] = (a >= DEPTH) ? '0 : DW'(m_mem[a]);
      end
    end
    g = -1;
    for (int i = 0; i < N && g < 0; i++)
      if (req[(m_rr + i) % N] && we[(m_rr + i) % N]) g = (m_rr + i) % N;
    if (g >= 0) begin
      a        = int'(addr_a[g]);
      e_ack[g] = 1'b1;
      e_err[g] = (a >= DEPTH);
      if (a < DEPTH) m_mem[a] = int'(wdata_a[g]);
      m_rr = (g + 1) % N;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0;
    we  = '0;
    for (int k = 0; k < N; k++) begin
      addr_a[k]  = '0;
      wdata_a[k] = '0;
    end
  endtask

  // Releases reset and walks the full CLEAR period with random (ignored) requests.
  task automatic clear_sequence();
    rst_n = 1'b1;
    for (int c = 0; c <= DEPTH; c++) begin
      req = (c == DEPTH) ? '0 : N'($urandom);
      we  = N'($urandom);
      for (int k = 0; k < N; k++) begin
        addr_a[k]  = AW'($urandom_range(0, 20));
        wdata_a[k] = DW'($urandom);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({ack, addr_err, all_done} !== '0) begin
        $display("FAIL clear_quiet c=%0d: ack=%b err=%b all_done=%b expected 0", c, ack, addr_err, all_done);
      end else n_pass++;
      n_checks++;
      if (start_process !== (c >= DEPTH)) begin
        $display("FAIL start_timing c=%0d: start_process=%b expected %b", c, start_process, c >= DEPTH);
      end else n_pass++;
    end
    idle_inputs();
    core_done = '0;
    model_reset();
    n_checks++;
    if (taps !== '0) $display("FAIL taps_after_clear: got %h expected 0", taps);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    core_done = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ack, addr_err, start_process, all_done, rdata, taps} !== '0)
      $display("FAIL reset_state: ack=%b err=%b start=%b done=%b rdata=%h taps=%h expected all 0",
               ack, addr_err, start_process, all_done, rdata, taps);
    else n_pass++;
    clear_sequence();
  endtask

  task automatic test_rr_contention();
    logic [N-1:0] pending;
    for (int round = 0; round < 2; round++) begin
      pending = '1;
      we = '1;
      for (int k = 0; k < N; k++) begin
        addr_a[k]  = AW'(5 + k + 5 * round);
        wdata_a[k] = DW'(12'h111 * (k + 1 + 4 * round));
      end
      for (int cyc = 0; cyc < N; cyc++) begin
        req = pending;
        tick();
        n_checks++;
        if (ack !== N'(1 << cyc)) $display("FAIL rr_order r%0d c%0d: ack=%b expected %b", round, cyc, ack, N'(1 << cyc));
        else n_pass++;
        pending = pending & ~N'(1 << cyc);
      end
    end
    req = 4'b0010; we = 4'b0010; addr_a[1] = 12'd20; wdata_a[1] = 12'h0AA;
    tick();
    n_checks++;
    if (ack !== 4'b0010) $display("FAIL rr_single1: ack=%b expected 0010", ack);
    else n_pass++;
    req = 4'b1100; we = 4'b1100; addr_a[2] = 12'd21; addr_a[3] = 12'd22;
    wdata_a[2] = 12'h0BB; wdata_a[3] = 12'h0CC;
    tick();
    n_checks++;
    if (ack !== 4'b0100) $display("FAIL rr_after1: ack=%b expected 0100", ack);
    else n_pass++;
    req = 4'b1000;
    tick();
    n_checks++;
    if (ack !== 4'b1000) $display("FAIL rr_then3: ack=%b expected 1000", ack);
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (taps[5*DW +: DW] !== 12'h111 || taps[8*DW +: DW] !== 12'h444 || taps[10*DW +: DW] !== 12'h555)
      $display("FAIL rr_taps: taps5=%h taps8=%h taps10=%h expected 111 444 555",
               taps[5*DW +: DW], taps[8*DW +: DW], taps[10*DW +: DW]);
    else n_pass++;
    n_checks++;
    if (taps !== e_taps) $display("FAIL rr_taps_model: got %h expected %h", taps, e_taps);
    else n_pass++;
  endtask

  task automatic test_read_before_write();
    req = 4'b0001; we = 4'b0001; addr_a[0] = 12'd9; wdata_a[0] = 12'hABC;
    tick();
    n_checks++;
    if (ack !== 4'b0001) $display("FAIL rbw_setup: ack=%b expected 0001", ack);
    else n_pass++;
    req = 4'b0011; we = 4'b0001; wdata_a[0] = 12'h123; addr_a[1] = 12'd9;
    tick();
    n_checks++;
    if (ack !== 4'b0011 || rdata[1*DW +: DW] !== 12'hABC)
      $display("FAIL rbw_same_cycle: ack=%b rdata1=%h expected 0011 ABC", ack, rdata[1*DW +: DW]);
    else n_pass++;
    n_checks++;
    if (taps[9*DW +: DW] !== 12'hABC) $display("FAIL rbw_tap_lag: taps9=%h expected ABC", taps[9*DW +: DW]);
    else n_pass++;
    req = 4'b0010; we = 4'b0000;
    tick();
    n_checks++;
    if (ack !== 4'b0010 || rdata[1*DW +: DW] !== 12'h123)
      $display("FAIL rbw_next_read: ack=%b rdata1=%h expected 0010 123", ack, rdata[1*DW +: DW]);
    else n_pass++;
    n_checks++;
    if (taps[9*DW +: DW] !== 12'h123) $display("FAIL rbw_tap: taps9=%h expected 123", taps[9*DW +: DW]);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_addr_err();
    req = 4'b1000; we = 4'b0000; addr_a[3] = 12'd9;
    tick();
    req = 4'b1000; we = 4'b0000; addr_a[3] = 12'd300;
    tick();
    n_checks++;
    if (ack !== 4'b1000 || addr_err !== 4'b1000 || rdata[3*DW +: DW] !== 12'h000)
      $display("FAIL err_read: ack=%b err=%b rdata3=%h expected 1000 1000 000", ack, addr_err, rdata[3*DW +: DW]);
    else n_pass++;
    we = 4'b1000; wdata_a[3] = 12'hFFF;
    tick();
    n_checks++;
    if (ack !== 4'b1000 || addr_err !== 4'b1000)
      $display("FAIL err_write: ack=%b err=%b expected 1000 1000", ack, addr_err);
    else n_pass++;
    addr_a[3] = 12'd255; wdata_a[3] = 12'h5A5;
    tick();
    n_checks++;
    if (ack !== 4'b1000 || addr_err !== 4'b0000)
      $display("FAIL err_top_write: ack=%b err=%b expected 1000 0000", ack, addr_err);
    else n_pass++;
    we = 4'b0000; addr_a[3] = 12'd44;
    tick();
    n_checks++;
    if (rdata[3*DW +: DW] !== 12'h000 || addr_err !== 4'b0000)
      $display("FAIL err_dropped: rdata3=%h err=%b expected 000 0000", rdata[3*DW +: DW], addr_err);
    else n_pass++;
    addr_a[3] = 12'd255;
    tick();
    n_checks++;
    if (rdata[3*DW +: DW] !== 12'h5A5) $display("FAIL err_top_read: rdata3=%h expected 5A5", rdata[3*DW +: DW]);
    else n_pass++;
    addr_a[3] = 12'd256;
    tick();
    n_checks++;
    if (addr_err !== 4'b1000 || rdata[3*DW +: DW] !== 12'h000)
      $display("FAIL err_depth_read: err=%b rdata3=%h expected 1000 000", addr_err, rdata[3*DW +: DW]);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [N-1:0] pending = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pending[k]) begin
          case ($urandom_range(0, 3))
            0: req[k] = 1'b0;
            1: begin req[k] = 1'b1; we[k] = 1'b0; end
            default: begin req[k] = 1'b1; we[k] = 1'b1; pending[k] = 1'b1; end
          endcase
          addr_a[k]  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(240, 320)) : AW'($urandom_range(0, 15));
          wdata_a[k] = DW'($urandom);
        end
      end
      tick();
      pending = pending & ~e_ack;
      n_checks++;
      if (ack !== e_ack) $display("FAIL rand_ack c=%0d: got %b expected %b", cyc, ack, e_ack);
      else n_pass++;
      n_checks++;
      if (addr_err !== e_err) $display("FAIL rand_err c=%0d: got %b expected %b", cyc, addr_err, e_err);
      else n_pass++;
      n_checks++;
      if (rdata !== e_rdata) $display("FAIL rand_rdata c=%0d: got %h expected %h", cyc, rdata, e_rdata);
      else n_pass++;
      n_checks++;
      if (taps !== e_taps) $display("FAIL rand_taps c=%0d: got %h expected %h", cyc, taps, e_taps);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    req = '1; we = '1;
    for (int k = 0; k < N; k++) begin
      addr_a[k]  = AW'(5 + k);
      wdata_a[k] = DW'(12'h700 + k);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ack !== '0 || start_process !== 1'b0)
      $display("FAIL mid_reset_async: ack=%b start=%b expected 0 0", ack, start_process);
    else n_pass++;
    idle_inputs();
    core_done = '1;
    repeat (2) @(posedge clk);
    #1;
    clear_sequence();
    req = '1; we = '0;
    for (int k = 0; k < N; k++) addr_a[k] = AW'(5 + k);
    tick();
    n_checks++;
    if (ack !== '1 || rdata !== '0) $display("FAIL mid_reset_cleared: ack=%b rdata=%h expected 1111 0", ack, rdata);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_all_done();
    n_checks++;
    if (all_done !== 1'b0) $display("FAIL done_idle: all_done=%b expected 0", all_done);
    else n_pass++;
    core_done = 4'b1111;
    tick();
    n_checks++;
    if (all_done !== 1'b1) $display("FAIL done_rise: all_done=%b expected 1", all_done);
    else n_pass++;
    core_done = 4'b1011;
    tick();
    n_checks++;
    if (all_done !== 1'b0) $display("FAIL done_drop: all_done=%b expected 0", all_done);
    else n_pass++;
    core_done = '0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_rr_contention();
    test_read_before_write();
    test_addr_err();
    test_random();
    test_all_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
